// File: rtl/calc_pkg.sv
// Shared calculator definitions: transmitter FSM states and default datapath width.
package calc_pkg;

  localparam int CALC_DATA_WIDTH = 32;

  typedef enum logic [1:0] {TX_IDLE, TX_LOADED, TX_SHIFT, TX_DONE} tx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period divider: counts 0..BIT_CYCLES-1 while enabled and strobes tick on the
// terminal count so the shifter advances once per serial bit.
module bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int DW = $clog2(BIT_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(BIT_CYCLES - 1);

  logic [DW-1:0] div;

  assign tick = enable && (div == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                div <= '0;
    else if (clear || tick)   div <= '0;
    else if (enable)          div <= div + 1'b1;
  end

endmodule

// File: rtl/serial_transceiver.sv
// Captures a result word and shifts it out MSB-first, then pulses txDone for the controller.
// Define SERIAL_PARITY_EN to append an even-parity bit after the LSB.
module serial_transceiver
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = CALC_DATA_WIDTH,
  parameter int BIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  sample,
  input  logic                  startTx,
  output logic                  txOut,
  output logic                  txValid,
  output logic                  txBusy,
  output logic                  txDone
);

`ifdef SERIAL_PARITY_EN
  localparam int TOTAL_BITS = DATA_WIDTH + 1;
`else
  localparam int TOTAL_BITS = DATA_WIDTH;
`endif
  localparam int BW = $clog2(DATA_WIDTH + 2);
  localparam logic [BW-1:0] BITS_INIT = BW'(TOTAL_BITS);

  tx_state_t             state, state_nxt;
  logic [TOTAL_BITS-1:0] shreg, shreg_nxt, capture_word;
  logic [BW-1:0]         bitcnt;
  logic                  load, start, tick;

`ifdef SERIAL_PARITY_EN
  // Parity rides in the LSB slot so it falls out right after the data LSB.
  assign capture_word = {dataIn, ^dataIn};
`else
  assign capture_word = dataIn;
`endif

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .enable (state == TX_SHIFT),
    .tick   (tick)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    start     = 1'b0;
    shreg_nxt = shreg;
    case (state)
      TX_IDLE, TX_LOADED: begin
        if (sample) begin
          load      = 1'b1;
          state_nxt = TX_LOADED;
        end
        if (startTx && (sample || state == TX_LOADED)) begin
          start     = 1'b1;
          state_nxt = TX_SHIFT;
        end
      end
      TX_SHIFT: if (tick && bitcnt == BW'(1)) state_nxt = TX_DONE;
      TX_DONE:  state_nxt = TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
    if (load)                          shreg_nxt = capture_word;
    else if (state == TX_SHIFT && tick) shreg_nxt = shreg << 1;
  end

  // Outputs are decoded from next-state so they are registered yet aligned with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= TX_IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      txOut   <= 1'b0;
      txValid <= 1'b0;
      txBusy  <= 1'b0;
      txDone  <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      if (start)                          bitcnt <= BITS_INIT;
      else if (state == TX_SHIFT && tick) bitcnt <= bitcnt - 1'b1;
      txOut   <= (state_nxt == TX_SHIFT) && shreg_nxt[TOTAL_BITS-1];
      txValid <= (state_nxt == TX_SHIFT);
      txBusy  <= (state_nxt == TX_SHIFT) || (state_nxt == TX_DONE);
      txDone  <= (state_nxt == TX_DONE);
    end
  end

endmodule

// File: tb/tb_serial_transceiver.sv
// Bench for serial_transceiver: two instances (BIT_CYCLES 1 and 3) share stimulus,
// each checked every cycle against a bit-schedule model, plus literal stream checks.
module tb_serial_transceiver;

  localparam int W = 8;
`ifdef SERIAL_PARITY_EN
  localparam int T = W + 1;
`else
  localparam int T = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sample = 1'b0;
  logic         startTx = 1'b0;
  logic [W-1:0] dataIn = '0;
  logic [1:0]   tx_out, tx_valid, tx_busy, tx_done;

  always #5 clk = ~clk;

  serial_transceiver #(.DATA_WIDTH(W), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .dataIn(dataIn), .sample(sample), .startTx(startTx),
    .txOut(tx_out[0]), .txValid(tx_valid[0]), .txBusy(tx_busy[0]), .txDone(tx_done[0]));

  serial_transceiver #(.DATA_WIDTH(W), .BIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .dataIn(dataIn), .sample(sample), .startTx(startTx),
    .txOut(tx_out[1]), .txValid(tx_valid[1]), .txBusy(tx_busy[1]), .txDone(tx_done[1]));

  int checks = 0;
  int passes = 0;
  int cycle_no = 0;

  // Model: once started, a transfer is T bits each held bc cycles, then one done cycle.
  int           bc[2] = '{1, 3};
  bit           active[2];
  bit           loaded[2];
  logic [W-1:0] word[2];
  logic [W-1:0] txword[2];
  int           cyc[2];

  function automatic logic bit_of(logic [W-1:0] w, int b);
    if (b < W) return w[W-1-b];
    return ^w;
  endfunction

  function automatic logic [3:0] expect_out(int i);  // {txOut, txValid, txBusy, txDone}
    if (reset || !active[i]) return 4'b0000;
    if (cyc[i] < T * bc[i]) return {bit_of(txword[i], cyc[i] / bc[i]), 3'b110};
    return 4'b0011;
  endfunction

  always @(posedge clk) begin
    cycle_no++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        active[i] = 1'b0;
        loaded[i] = 1'b0;
      end else if (active[i]) begin
        if (cyc[i] == T * bc[i]) active[i] = 1'b0;
        else cyc[i]++;
      end else begin
        if (sample) begin
          word[i]   = dataIn;
          loaded[i] = 1'b1;
        end
        if (startTx && loaded[i]) begin
          active[i] = 1'b1;
          cyc[i]    = 0;
          loaded[i] = 1'b0;
          txword[i] = word[i];
        end
      end
    end
  end

  // Per-cycle compare and stream recording.
  logic [15:0] rec1;
  int          nrec1;
  int          activity;
  int          done_cnt;
  int          done1_cycle, done3_cycle;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0] got, exp;
      got = {tx_out[i], tx_valid[i], tx_busy[i], tx_done[i]};
      exp = expect_out(i);
      checks++;
      if (got !== exp)
        $display("FAIL cycle_compare edge%0d dut%0d {out,valid,busy,done} got %b want %b",
                 cycle_no, i, got, exp);
      else passes++;
    end
    if (tx_valid[0]) begin
      rec1 = {rec1[14:0], tx_out[0]};
      nrec1++;
    end
    if (tx_valid != 2'b00 || tx_done != 2'b00) activity++;
    if (tx_done != 2'b00) done_cnt++;
    if (tx_done[0]) done1_cycle = cycle_no;
    if (tx_done[1]) done3_cycle = cycle_no;
  end

  task automatic check_lit(string name, int got, int want);
    checks++;
    if (got !== want) $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    else passes++;
  endtask

  task automatic drive(logic s, logic st, logic [W-1:0] d);
    @(posedge clk);
    #2;
    sample  = s;
    startTx = st;
    dataIn  = d;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #2;
      if (!active[0] && !active[1] && tx_busy == 2'b00) return;
    end
    checks++;
    $display("FAIL idle_timeout got busy=%b want 00 within 200 cycles", tx_busy);
  endtask

  task automatic clear_rec();
    rec1  = '0;
    nrec1 = 0;
  endtask

  int start_edge;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_lit("reset_outputs", {tx_out, tx_valid, tx_busy, tx_done}, 0);
    #1;
    reset = 1'b0;

    // Basic transmit of A5; the divided instance also runs alongside.
    drive(1'b1, 1'b0, 8'hA5);
    clear_rec();
    drive(1'b0, 1'b1, 8'h00);
    start_edge = cycle_no + 1;
    drive(1'b0, 1'b0, 8'h00);
    wait_idle();
`ifdef SERIAL_PARITY_EN
    check_lit("a5_stream", rec1, 16'h014A);
`else
    check_lit("a5_stream", rec1, 16'h00A5);
`endif
    check_lit("a5_nbits", nrec1, T);
    check_lit("b1_done_cycle", done1_cycle - start_edge + 1, T + 1);

    // Bit divider with 81.
    drive(1'b1, 1'b0, 8'h81);
    drive(1'b0, 1'b1, 8'h00);
    start_edge = cycle_no + 1;
    drive(1'b0, 1'b0, 8'h00);
    wait_idle();
`ifdef SERIAL_PARITY_EN
    check_lit("b3_done_cycle", done3_cycle - start_edge + 1, 28);
`else
    check_lit("b3_done_cycle", done3_cycle - start_edge + 1, 25);
`endif

    // Simultaneous sample and start from IDLE.
    clear_rec();
    drive(1'b1, 1'b1, 8'h3C);
    drive(1'b0, 1'b0, 8'h00);
    wait_idle();
`ifdef SERIAL_PARITY_EN
    check_lit("3c_stream", rec1, 16'h0078);
`else
    check_lit("3c_stream", rec1, 16'h003C);
`endif

    // Start with nothing loaded: nothing happens.
    activity = 0;
    drive(1'b0, 1'b1, 8'h00);
    repeat (10) drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    check_lit("empty_start_activity", activity, 0);

    // Sample during SHIFT ignored; startTx held through DONE does not retransmit.
    clear_rec();
    drive(1'b1, 1'b0, 8'h0F);
    drive(1'b0, 1'b1, 8'h00);
    repeat (3) drive(1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'hFF);
    drive(1'b0, 1'b1, 8'h00);
    wait_idle();
`ifdef SERIAL_PARITY_EN
    check_lit("0f_stream", rec1, 16'h001E);
`else
    check_lit("0f_stream", rec1, 16'h000F);
`endif
    activity = 0;
    repeat (12) drive(1'b0, 1'b1, 8'h00);
    check_lit("held_start_activity", activity, 0);
    drive(1'b0, 1'b0, 8'h00);

    // Reset during bit 4 of dut1.
    drive(1'b1, 1'b0, 8'h96);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    done_cnt = 0;
    reset = 1'b1;
    #1;
    check_lit("reset_mid_outputs", {tx_out, tx_valid, tx_busy, tx_done}, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    check_lit("reset_no_done", done_cnt, 0);

    // Fresh transfer after reset.
    clear_rec();
    drive(1'b1, 1'b1, 8'h55);
    drive(1'b0, 1'b0, 8'h00);
    wait_idle();
`ifdef SERIAL_PARITY_EN
    check_lit("55_stream", rec1, 16'h00AA);
`else
    check_lit("55_stream", rec1, 16'h0055);
`endif

    // Odd-weight word; parity bit is 1 when enabled.
    clear_rec();
    drive(1'b1, 1'b1, 8'h07);
    drive(1'b0, 1'b0, 8'h00);
    wait_idle();
`ifdef SERIAL_PARITY_EN
    check_lit("07_stream", rec1, 16'h000F);
`else
    check_lit("07_stream", rec1, 16'h0007);
`endif
    check_lit("07_nbits", nrec1, T);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_transceiver.md
# serial_transceiver

Parallel-to-serial output stage of the binary calculator, directly downstream of `Controller`. It captures a result word on `SampleData`, shifts it out MSB-first on a single serial line when the controller raises `TxData`, and returns a one-cycle `txDone` pulse that feeds the controller's `txDone` input so the controller can leave its transmit state.

## Interface
- `DATA_WIDTH`, 32: width of the captured word; legal range 1 and up.
- `BIT_CYCLES`, 1: clock cycles each serial bit is held; legal range 1 and up.
- `clk` input 1: single clock; all flops are rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `dataIn` input DATA_WIDTH: result word to transmit.
- `sample` input 1: capture strobe, driven by `SampleData`.
- `startTx` input 1: transmit request, driven by `TxData`; level-sensitive.
- `txOut` output 1: serial data bit.
- `txValid` output 1: high while `txOut` carries a data or parity bit.
- `txBusy` output 1: high in SHIFT and DONE.
- `txDone` output 1: one-cycle completion pulse; drives `Controller.txDone`.

## Operation
- The FSM has four states: IDLE, LOADED, SHIFT and DONE. It enters IDLE on reset.
- **IDLE:**
  - `sample`=1 loads `dataIn` into the shift register and moves to LOADED.
  - `startTx` alone is ignored, because there is no valid data.
- **LOADED:**
  - `sample`=1 reloads the shift register; the newest word wins.
  - `startTx`=1 moves to SHIFT. The bit counter is set to the total bit count, and the divider is set to 0.
- **Simultaneous `sample` and `startTx` in IDLE or LOADED:**
  - The capture happens in that same cycle.
  - Transmission starts from the newly captured word.
  - The next state is SHIFT.
- **SHIFT:**
  - `txOut` = shift register MSB and `txValid`=1.
  - The divider counts 0..BIT_CYCLES-1. At terminal count the register shifts left by 1, filling with 0, and the bit counter decrements.
  - When the last bit's terminal count is reached, the FSM moves to DONE.
  - `sample` and `startTx` are ignored in SHIFT.
- **DONE:**
  - `txDone`=1 and `txValid`=0 for exactly one cycle.
  - The next state is IDLE unconditionally. The data is consumed, so holding `startTx` high does not retransmit.
- **Output values outside SHIFT:** `txOut`=0 and `txValid`=0.
- **Counter widths:**
  - Bit counter: `$clog2(DATA_WIDTH+2)`.
  - Divider: `$clog2(BIT_CYCLES+1)`.
  - Both counters are unsigned, and neither wraps: each is reloaded on entry to SHIFT.

## Timing
- **Reset values:**
  - `txOut`=0, `txValid`=0, `txBusy`=0, `txDone`=0.
  - Shift register = 0, state = IDLE.
- **Reset mid-operation:**
  - An asserted `reset` clears the block immediately, even mid-SHIFT.
  - No `txDone` is produced for the aborted word.
- **Capture:** `dataIn` is sampled on the rising edge where `sample`=1.
- **Transmit latency:**
  - `startTx` is seen high at edge N.
  - The first bit (MSB) appears on `txOut`, with `txValid`=1, after edge N.
  - Bit k occupies cycles N+1+k·BIT_CYCLES through N+(k+1)·BIT_CYCLES.
- **Completion:**
  - Let T = total bit count: DATA_WIDTH, or DATA_WIDTH+1 with parity enabled.
  - `txDone` is high in cycle N+1+T·BIT_CYCLES.
  - `txBusy` is high from cycle N+1 through that cycle inclusive.
- **Output registering:** all outputs are registered, with no combinational path from any input to any output.

## Configuration
- **`SERIAL_PARITY_EN` defined:**
  - After the LSB, one even-parity bit (XOR of the captured word) is sent for BIT_CYCLES cycles with `txValid`=1.
  - T = DATA_WIDTH+1.
  - Parity is computed at capture time and stored alongside the word.
- **`SERIAL_PARITY_EN` undefined:**
  - T = DATA_WIDTH.
  - No parity logic is instantiated.

## Structure
- Shared package `calc_pkg` holds:
  - `typedef enum logic [1:0] {TX_IDLE, TX_LOADED, TX_SHIFT, TX_DONE} tx_state_t`.
  - A default width constant, `CALC_DATA_WIDTH`=32.
- One sub-module, `bit_timer`:
  - Parameterised by BIT_CYCLES.
  - Inputs: `clk`, `reset`, `clear`, `enable`.
  - Output: the `tick` terminal-count strobe, which advances the shifter.
- FSM, shift register, bit counter and output registers live in `serial_transceiver`.

## Test plan
- **Basic transmit:** DATA_WIDTH=8, BIT_CYCLES=1. `sample` with `dataIn`=8'hA5, then `startTx` → `txOut` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with `txValid`=1, then `txDone`=1 for one cycle, then IDLE.
- **Bit divider:** BIT_CYCLES=3, `dataIn`=8'h81 → each bit held 3 cycles; `txDone` at cycle N+25 (N+28 with parity).
- **Simultaneous capture and start:** `sample` and `startTx` in the same cycle from IDLE with 8'h3C → 0,0,1,1,1,1,0,0. Separately, `startTx` with nothing loaded → no `txValid` and no `txDone`.
- **Ignored inputs during SHIFT:** `sample`=1 with 8'hFF mid-SHIFT of 8'h0F → the transmitted stream is still 8'h0F. `startTx` held high through DONE → no second transmission.
- **Reset mid-shift:** assert `reset` on bit 4 → all outputs 0 immediately and no `txDone`. After release, a new transfer of 8'h55 completes normally.
- **Parity (`SERIAL_PARITY_EN`):** 8'hA5 → parity bit 0; 8'h07 → parity bit 1; `txDone` follows the parity bit.
